// File: rtl/instr_mem_loader_pkg.sv
// Shared constants for the instruction-memory loader and the memory it fills:
// default geometry and the loader FSM state encoding.
package instr_mem_loader_pkg;

    localparam int IML_ADDR_W = 10;
    localparam int IML_DATA_W = 32;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ASSEMBLE = 2'd1;
    localparam logic [1:0] ST_WRITE    = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    // An empty load skips straight to the completion pulse.
    function automatic logic [1:0] start_target(input logic len_is_zero);
        logic [1:0] nxt;
        nxt = len_is_zero ? ST_DONE : ST_ASSEMBLE;
        return nxt;
    endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Big-endian byte packer: shifts accepted bytes into a word and flags the
// byte that completes it (first byte lands in the most significant lane).
module instr_mem_loader_byte_packer
    import instr_mem_loader_pkg::*;
#(
    parameter int DATA_W = IML_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word_next,
    output logic              o_word_complete
);

    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    // Only the lower lanes need storage; the top lane is shifted out on completion.
    logic [DATA_W-9:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;

    assign o_word_next     = {r_acc, i_byte};
    assign o_word_complete = i_accept && (r_cnt == CNT_W'(BYTES - 1));

    // Accumulator and byte counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_accept) begin
            r_acc <= o_word_next[DATA_W-9:0];
            r_cnt <= o_word_complete ? '0 : (r_cnt + CNT_W'(1));
        end else begin
            r_acc <= r_acc;
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams program bytes into instruction memory: assembles words, writes one
// word per WRITE cycle at base+index, and pulses done when the load finishes.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W = IML_ADDR_W,
    parameter int DATA_W = IML_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              busy,
    output logic              done
);

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_idx;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic              r_byte_ready;
    logic              r_busy;
    logic              r_done;

    logic [1:0]        w_next_state;
    logic              w_accept;
    logic              w_start_go;
    logic [ADDR_W:0]   w_idx_inc;
    logic [DATA_W-1:0] w_word_next;
    logic              w_word_complete;

    assign w_accept   = byte_valid && (r_state == ST_ASSEMBLE);
    assign w_start_go = start && (r_state == ST_IDLE);
    assign w_idx_inc  = r_idx + {{ADDR_W{1'b0}}, 1'b1};

    instr_mem_loader_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_clear         (w_start_go),
        .i_accept        (w_accept),
        .i_byte          (byte_in),
        .o_word_next     (w_word_next),
        .o_word_complete (w_word_complete)
    );

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = start_target(load_len == '0);
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ASSEMBLE: begin
                if (w_word_complete) begin
                    w_next_state = ST_WRITE;
                end else begin
                    w_next_state = ST_ASSEMBLE;
                end
            end
            ST_WRITE: begin
                if (w_idx_inc == r_len) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_ASSEMBLE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // State, load context and registered outputs; outputs follow the next state
    // so they are valid for the whole cycle the FSM spends in that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_base       <= '0;
            r_idx        <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_mem_we     <= (w_next_state == ST_WRITE);
            r_byte_ready <= (w_next_state == ST_ASSEMBLE);
            r_busy       <= (w_next_state != ST_IDLE);
            r_done       <= (w_next_state == ST_DONE);

            if (w_start_go) begin
                r_len  <= load_len;
                r_base <= base_addr;
                r_idx  <= '0;
            end else if (r_state == ST_WRITE) begin
                r_idx  <= w_idx_inc;
            end else begin
                r_idx  <= r_idx;
            end

            // Address wraps naturally at ADDR_W bits.
            if (w_word_complete) begin
                r_mem_addr <= r_base + r_idx[ADDR_W-1:0];
                r_mem_din  <= w_word_next;
            end else begin
                r_mem_addr <= r_mem_addr;
                r_mem_din  <= r_mem_din;
            end
        end
    end

    assign byte_ready = r_byte_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: hand-computed words and addresses,
// a negedge monitor logs every memory write and done pulse.
module tb_instr_mem_loader;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   load_len;
    logic [AW-1:0] base_addr;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int rdy_cnt  = 0;
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    logic [7:0]    fq[$];

    instr_mem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_len   (load_len),
        .base_addr  (base_addr),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_din);
        end
        if (done === 1'b1) done_cnt++;
        if (byte_ready === 1'b1) rdy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_cnt = 0;
        rdy_cnt  = 0;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
        start     = 1'b1;
        base_addr = b;
        load_len  = n;
        tick();
        start     = 1'b0;
        base_addr = 10'h155;
        load_len  = 11'd7;
    endtask

    task automatic push_word(input logic [31:0] w);
        fq.push_back(w[31:24]);
        fq.push_back(w[23:16]);
        fq.push_back(w[15:8]);
        fq.push_back(w[7:0]);
    endtask

    // Hands every queued byte over; gap=1 idles byte_valid one cycle before each byte.
    task automatic feed(input bit gap);
        logic [7:0] b;
        bit got;
        while (fq.size() > 0) begin
            b = fq.pop_front();
            if (gap) begin
                byte_valid = 1'b0;
                tick();
            end
            byte_valid = 1'b1;
            byte_in    = b;
            got = 1'b0;
            for (int g = 0; g < 20 && !got; g++) begin
                got = byte_ready;
                tick();
            end
            if (!got) chk("feed_timeout", 64'd0, 64'd1);
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int k = 0;
        while (done !== 1'b1 && k < max) begin
            tick();
            k++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    initial begin
        int t0;
        int errs;
        logic [9:0]  iv;
        logic [31:0] w;
        logic [AW-1:0] ea;

        reset = 1'b1; start = 1'b0; load_len = '0; base_addr = '0;
        byte_in = 8'h00; byte_valid = 1'b0;
        tick(); tick();
        chk("rst_busy",  {63'd0, busy},       64'd0);
        chk("rst_done",  {63'd0, done},       64'd0);
        chk("rst_we",    {63'd0, mem_we},     64'd0);
        chk("rst_ready", {63'd0, byte_ready}, 64'd0);
        chk("rst_addr",  {54'd0, mem_addr},   64'd0);
        chk("rst_din",   {32'd0, mem_din},    64'd0);
        reset = 1'b0;

        // Single word, inspected cycle by cycle.
        clear_log();
        do_start(10'h000, 11'd1);
        chk("t1_ready", {63'd0, byte_ready}, 64'd1);
        chk("t1_busy",  {63'd0, busy},       64'd1);
        push_word(32'h8C010004);
        feed(1'b0);
        chk("t1_we",    {63'd0, mem_we},     64'd1);
        chk("t1_addr",  {54'd0, mem_addr},   64'd0);
        chk("t1_din",   {32'd0, mem_din},    64'h8C010004);
        chk("t1_noready", {63'd0, byte_ready}, 64'd0);
        tick();
        chk("t1_done",  {63'd0, done},       64'd1);
        chk("t1_we_off", {63'd0, mem_we},    64'd0);
        chk("t1_din_hold", {32'd0, mem_din}, 64'h8C010004);
        tick();
        chk("t1_done_off", {63'd0, done},    64'd0);
        chk("t1_idle",  {63'd0, busy},       64'd0);
        chk("t1_nwr",   64'(wa.size()),      64'd1);

        // Three words across the top of the address space.
        clear_log();
        do_start(10'h3FE, 11'd3);
        t0 = cyc;
        for (int i = 0; i < 12; i++) fq.push_back(8'(i));
        feed(1'b0);
        wait_done(20);
        chk("t2_cycles", 64'(cyc - t0),      64'd15);
        tick();
        chk("t2_nwr",   64'(wa.size()),      64'd3);
        chk("t2_a0",    {54'd0, wa[0]},      64'h3FE);
        chk("t2_a1",    {54'd0, wa[1]},      64'h3FF);
        chk("t2_a2",    {54'd0, wa[2]},      64'h000);
        chk("t2_d0",    {32'd0, wd[0]},      64'h00010203);
        chk("t2_d1",    {32'd0, wd[1]},      64'h04050607);
        chk("t2_d2",    {32'd0, wd[2]},      64'h08090A0B);
        chk("t2_ndone", 64'(done_cnt),       64'd1);

        // Empty load.
        clear_log();
        do_start(10'h0AA, 11'd0);
        chk("t3_done",  {63'd0, done},       64'd1);
        chk("t3_ready", {63'd0, byte_ready}, 64'd0);
        tick();
        chk("t3_done_off", {63'd0, done},    64'd0);
        chk("t3_idle",  {63'd0, busy},       64'd0);
        chk("t3_nwr",   64'(wa.size()),      64'd0);
        chk("t3_nrdy",  64'(rdy_cnt),        64'd0);

        // Gapped byte stream.
        clear_log();
        do_start(10'h010, 11'd2);
        push_word(32'hDEADBEEF);
        push_word(32'h12345678);
        feed(1'b1);
        wait_done(20);
        tick();
        chk("t4_nwr",   64'(wa.size()),      64'd2);
        chk("t4_a0",    {54'd0, wa[0]},      64'h010);
        chk("t4_a1",    {54'd0, wa[1]},      64'h011);
        chk("t4_d0",    {32'd0, wd[0]},      64'hDEADBEEF);
        chk("t4_d1",    {32'd0, wd[1]},      64'h12345678);

        // Reset in the middle of a word, then a fresh load.
        clear_log();
        do_start(10'h020, 11'd1);
        fq.push_back(8'hAA);
        fq.push_back(8'hBB);
        feed(1'b0);
        reset = 1'b1;
        tick();
        chk("t5_busy",  {63'd0, busy},       64'd0);
        chk("t5_ready", {63'd0, byte_ready}, 64'd0);
        chk("t5_we",    {63'd0, mem_we},     64'd0);
        chk("t5_done",  {63'd0, done},       64'd0);
        chk("t5_addr",  {54'd0, mem_addr},   64'd0);
        chk("t5_din",   {32'd0, mem_din},    64'd0);
        start = 1'b1; load_len = 11'd1; base_addr = 10'h001;
        tick();
        chk("t5_rst_prio", {63'd0, busy},    64'd0);
        start = 1'b0;
        reset = 1'b0;
        clear_log();
        do_start(10'h005, 11'd1);
        push_word(32'h11223344);
        feed(1'b0);
        wait_done(20);
        tick();
        chk("t5_nwr",   64'(wa.size()),      64'd1);
        chk("t5_a0",    {54'd0, wa[0]},      64'h005);
        chk("t5_d0",    {32'd0, wd[0]},      64'h11223344);

        // Second start while busy must be ignored.
        clear_log();
        do_start(10'h100, 11'd2);
        fq.push_back(8'hCA);
        fq.push_back(8'hFE);
        feed(1'b0);
        start = 1'b1; base_addr = 10'h200; load_len = 11'd1;
        tick();
        start = 1'b0;
        fq.push_back(8'hF0);
        fq.push_back(8'h0D);
        push_word(32'h55AA33CC);
        feed(1'b0);
        wait_done(20);
        tick();
        chk("t6_nwr",   64'(wa.size()),      64'd2);
        chk("t6_a0",    {54'd0, wa[0]},      64'h100);
        chk("t6_a1",    {54'd0, wa[1]},      64'h101);
        chk("t6_d0",    {32'd0, wd[0]},      64'hCAFEF00D);
        chk("t6_d1",    {32'd0, wd[1]},      64'h55AA33CC);

        // Full-memory load starting mid-range, wraps past the top address.
        clear_log();
        do_start(10'h2A5, 11'd1024);
        t0 = cyc;
        for (int i = 0; i < 1024; i++) begin
            iv = 10'(i);
            push_word({iv[7:0], ~iv[7:0], 6'd0, iv[9:8], 8'h5A});
        end
        feed(1'b0);
        wait_done(20);
        chk("t7_cycles", 64'(cyc - t0),      64'd5120);
        tick();
        chk("t7_nwr",   64'(wa.size()),      64'd1024);
        errs = 0;
        for (int i = 0; i < 1024 && i < wa.size(); i++) begin
            iv = 10'(i);
            ea = 10'h2A5 + iv;
            w  = {iv[7:0], ~iv[7:0], 6'd0, iv[9:8], 8'h5A};
            if (wa[i] !== ea || wd[i] !== w) errs++;
        end
        chk("t7_stream", 64'(errs),          64'd0);
        chk("t7_last",  {54'd0, wa[1023]},   64'h2A4);
        chk("t7_ndone", 64'(done_cnt),       64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
